// File: rtl/write_ram.sv
//==============================================================================
// Module      : write_ram
// Description : Serializer and RAM writer. Captures one wide result vector per
//               four-phase handshake and writes it LSW first as consecutive
//               DATA_W-bit words into a single-port block RAM.
//               Optional macro WRITE_RAM_APPEND_EN: when defined the write
//               pointer persists across vectors (packed back to back); when
//               undefined every capture restarts at BASE_ADDR.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module write_ram #(
  parameter int VEC_W     = 3072,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [VEC_W-1:0]  vec_in,
  input  logic              vec_en,
  output logic              vec_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done
);

  localparam int WORDS = VEC_W / DATA_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);

  logic [0:0]        state_q, state_d;
  logic [VEC_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;     // index of the word currently on ram_data
  logic [ADDR_W-1:0] ptr_q,   ptr_d;     // next address to be written
  logic              ack_q,   ack_d;
  logic              en_q,    en_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic              capture;
  logic [ADDR_W-1:0] start_addr;

  // A held request never re-triggers: a capture needs the previous ack released.
  assign capture = (state_q == S_IDLE) && vec_en && !ack_q;

`ifdef WRITE_RAM_APPEND_EN
  assign start_addr = ptr_q;
`else
  assign start_addr = BASE;
`endif

  // State and registered outputs; reset abandons any partial vector at once.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= BASE;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: leave IDLE on capture, return once the last word is out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (capture) state_d = S_WRITE;
      S_WRITE: if (cnt_q == LAST_WORD) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; address/data are zeroed when not writing.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ack_d   = ack_q ? vec_en : capture;
    en_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (capture) begin
      shreg_d = vec_in >> DATA_W;
      data_d  = vec_in[DATA_W-1:0];
      addr_d  = start_addr;
      ptr_d   = start_addr + ADDR_W'(1);
      cnt_d   = '0;
      en_d    = 1'b1;
      busy_d  = 1'b1;
    end else if (state_q == S_WRITE) begin
      if (cnt_q == LAST_WORD) begin
        done_d = 1'b1;
      end else begin
        shreg_d = shreg_q >> DATA_W;
        data_d  = shreg_q[DATA_W-1:0];
        addr_d  = ptr_q;
        ptr_d   = ptr_q + ADDR_W'(1);
        cnt_d   = cnt_q + CNT_W'(1);
        en_d    = 1'b1;
        busy_d  = 1'b1;
      end
    end
  end

  assign vec_ack  = ack_q;
  assign ram_en   = en_q;
  assign ram_we   = en_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire
